vrf_write_arbiter: RTL and testbench
====================================

Name: vrf_write_arbiter

Overview:
- Shares the single write port of the 32x128 vector register file between two producers: requester 0 (vector ALU writeback) and requester 1 (vector load unit).
- Registers the winning write on posedge so it is stable when the register file samples on negedge.
- Keeps a 32-entry pending-write scoreboard so issue logic can detect RAW hazards on vector registers.

Parameters:
- DATA_W, 128, write data width (one vector register)
- ADDR_W, 5, register address width; 2**ADDR_W scoreboard entries
- CNT_W, 16, perf counter width (used only with VRF_ARB_PERF_EN)

Ports:
- clock  in  1  system clock; all state on posedge
- async_reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester write request
- req_ready  out  2  per-requester grant; combinational, at most one bit set
- req_addr_0, req_addr_1  in  ADDR_W each  destination register
- req_data_0, req_data_1  in  DATA_W each  write data
- hold  in  1  freeze arbitration (pipeline stall); no grants while 1
- write_enable  out  1  to register file write_enable
- write_addr  out  ADDR_W  to register file write_addr
- write_data  out  DATA_W  to register file write_data
- reserve_valid  in  1  issue stage reserves a destination register
- reserve_addr  in  ADDR_W  register being reserved
- check_addr_1, check_addr_2  in  ADDR_W  source operands to check
- hazard_1, hazard_2  out  1  pending bit of check_addr_n; combinational
- pending  out  2**ADDR_W  full scoreboard vector
- conflict_count  out  CNT_W  cycles a valid requester lost arbitration

Behaviour:
- Reset (async, active-low), asynchronous and effective immediately, also mid-write:
  - write_enable=0, write_addr=0, write_data=0.
  - pending=0.
  - last_grant=1, so requester 0 wins the first tie.
  - conflict_count=0.
- Grant (combinational):
  - If hold=1: req_ready=00.
  - Else, one valid only: grant it.
  - Else, both valid: grant the requester other than last_grant.
  - Transfer = req_valid[i] & req_ready[i].
- Output stage:
  - On posedge with a transfer: write_addr/write_data <= granted request; write_enable <= (addr != 0); last_grant <= i.
  - Without a transfer: write_enable <= 0; addr/data hold their previous values.
  - Latency: transfer at posedge N -> write_enable high through cycle N+1 -> register file writes at the negedge inside N+1.
  - Sustained throughput: one write per cycle.
- Address 0: accepted (ready honoured) but dropped; write_enable stays 0; the scoreboard is not touched.
- last_grant updates only on a transfer; a hold cycle does not change priority.
- Scoreboard, on posedge:
  - Clear: if write_enable=1, pending[write_addr] <= 0.
  - Set: if reserve_valid=1 and reserve_addr!=0, pending[reserve_addr] <= 1.
  - Same address in the same cycle: set wins (new producer).
  - Reserving an already-pending register: stays 1 (single-bit, no count).
  - pending[0] is constantly 0.
- Hazard outputs:
  - hazard_n = pending[check_addr_n], combinational; 0 for address 0.
  - A register reads as hazardous through the cycle in which its write_enable is high. It clears at the following posedge, after the negedge write has landed.
- Writes to a register that is not pending are legal; the register file is updated and the scoreboard is unchanged.

Optional Feature:
- Macro VRF_ARB_PERF_EN.
- Defined: conflict_count increments on posedge when req_valid=11, hold=0 and one requester is refused. It saturates at 2**CNT_W-1 and never wraps. It is cleared only by reset.
- Undefined: no counter logic; conflict_count is tied to 0.

Test Plan:
- Reset then single write: req_valid=01, addr 5, data 0xAAAA...; hold=0 -> req_ready=01; next cycle write_enable=1, write_addr=5, write_data=0xAAAA...; following cycle write_enable=0.
- Tie round-robin: both valid for 4 cycles, addrs 3/7 -> grants 0,1,0,1; write_addr sequence 3,7,3,7. With VRF_ARB_PERF_EN, conflict_count=4. Without it, conflict_count=0.
- Hold: both valid, hold=1 for 3 cycles -> req_ready=00 and write_enable=0 throughout. Release hold -> requester 0 granted first.
- Scoreboard: reserve addr 9 -> pending[9]=1 and hazard_1=1 with check_addr_1=9. Requester 1 writes addr 9 -> hazard_1 stays 1 during the write_enable cycle and reads 0 the cycle after.
- Set/clear collision and addr 0: write_enable to addr 12 while reserve addr 12 -> pending[12] stays 1. Reserve addr 0 -> pending unchanged. Request addr 0 -> accepted, write_enable=0.
- Reset mid-operation: assert async_reset=0 while write_enable=1 and pending=0xFFFF_FFFE -> immediately write_enable=0 and pending=0. After release, a tie grants requester 0.

Source files
------------

// File: rtl/vrf_write_arbiter.sv
// Write-port arbiter for the vector register file: round-robin between ALU and load unit,
// registered write stage, and a pending-write scoreboard. Optional conflict counter via VRF_ARB_PERF_EN.
module vrf_write_arbiter #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   async_reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [ADDR_W-1:0]      req_addr_0,
  input  logic [ADDR_W-1:0]      req_addr_1,
  input  logic [DATA_W-1:0]      req_data_0,
  input  logic [DATA_W-1:0]      req_data_1,
  input  logic                   hold,
  output logic                   write_enable,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [DATA_W-1:0]      write_data,
  input  logic                   reserve_valid,
  input  logic [ADDR_W-1:0]      reserve_addr,
  input  logic [ADDR_W-1:0]      check_addr_1,
  input  logic [ADDR_W-1:0]      check_addr_2,
  output logic                   hazard_1,
  output logic                   hazard_2,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [CNT_W-1:0]       conflict_count
);

  localparam int NREG = 2**ADDR_W;

  logic              last_grant;
  logic [1:0]        xfer;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_next;

  always_comb begin
    req_ready = 2'b00;
    if (!hold) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign xfer     = req_valid & req_ready;
  assign win      = xfer[1];
  assign win_addr = win ? req_addr_1 : req_addr_0;
  assign win_data = win ? req_data_1 : req_data_0;

  // address 0 is accepted but never reaches the register file
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      last_grant   <= 1'b1;
    end else if (|xfer) begin
      write_enable <= (win_addr != '0);
      write_addr   <= win_addr;
      write_data   <= win_data;
      last_grant   <= win;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // set after clear so a new reservation beats a retiring write to the same register
  always_comb begin
    pend_next = pend_q;
    if (write_enable) pend_next[write_addr] = 1'b0;
    if (reserve_valid && (reserve_addr != '0)) pend_next[reserve_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) pend_q <= '0;
    else              pend_q <= pend_next;
  end

  assign pending  = pend_q;
  assign hazard_1 = pend_q[check_addr_1];
  assign hazard_2 = pend_q[check_addr_2];

`ifdef VRF_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q;
  logic             conflict;

  assign conflict = (req_valid == 2'b11) && !hold;

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset)                 cnt_q <= '0;
    else if (conflict && (cnt_q != '1)) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign conflict_count = cnt_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Directed, table-driven bench for vrf_write_arbiter: arbitration, hold, write stage,
// scoreboard set/clear, address 0 handling and asynchronous reset.
module tb_vrf_write_arbiter;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
`ifdef VRF_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [DATA_W-1:0] D0 = {32{4'hA}};
  localparam logic [DATA_W-1:0] D1 = {32{4'h5}};

  logic              clock = 1'b0;
  logic              async_reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] req_addr_0, req_addr_1;
  logic [DATA_W-1:0] req_data_0, req_data_1;
  logic              hold;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              reserve_valid;
  logic [ADDR_W-1:0] reserve_addr;
  logic [ADDR_W-1:0] check_addr_1, check_addr_2;
  logic              hazard_1, hazard_2;
  logic [31:0]       pending;
  logic [CNT_W-1:0]  conflict_count;

  int tests = 0;
  int fails = 0;

  vrf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .async_reset(async_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .hold(hold),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .check_addr_1(check_addr_1), .check_addr_2(check_addr_2),
    .hazard_1(hazard_1), .hazard_2(hazard_2),
    .pending(pending), .conflict_count(conflict_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one record per clock: inputs, combinational expectations before the edge,
  // registered expectations after the edge
  typedef struct {
    logic [1:0]  valid;
    logic        hold;
    logic [4:0]  a0, a1;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  chk;
    logic [1:0]  exp_ready;
    logic        exp_hz1, exp_hz2;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic        exp_src;
    logic [31:0] exp_pend;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // valid hold a0 a1 rv ra chk | ready hz1 hz2 | we wa src pend cnt
    vecs[0]  = '{2'b11, 0, 3, 7, 0, 0, 0,  2'b01, 0, 0, 1, 3,  0, 32'h0, 1};
    vecs[1]  = '{2'b11, 0, 3, 7, 0, 0, 0,  2'b10, 0, 0, 1, 7,  1, 32'h0, 2};
    vecs[2]  = '{2'b11, 0, 3, 7, 0, 0, 0,  2'b01, 0, 0, 1, 3,  0, 32'h0, 3};
    vecs[3]  = '{2'b11, 0, 3, 7, 0, 0, 0,  2'b10, 0, 0, 1, 7,  1, 32'h0, 4};
    vecs[4]  = '{2'b11, 1, 3, 7, 0, 0, 0,  2'b00, 0, 0, 0, 7,  0, 32'h0, 4};
    vecs[5]  = '{2'b11, 1, 3, 7, 0, 0, 0,  2'b00, 0, 0, 0, 7,  0, 32'h0, 4};
    vecs[6]  = '{2'b11, 1, 3, 7, 0, 0, 0,  2'b00, 0, 0, 0, 7,  0, 32'h0, 4};
    vecs[7]  = '{2'b11, 0, 3, 7, 0, 0, 0,  2'b01, 0, 0, 1, 3,  0, 32'h0, 5};
    vecs[8]  = '{2'b01, 0, 5, 0, 0, 0, 0,  2'b01, 0, 0, 1, 5,  0, 32'h0, 5};
    vecs[9]  = '{2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 5,  0, 32'h0, 5};
    vecs[10] = '{2'b00, 0, 0, 0, 1, 9, 9,  2'b00, 0, 0, 0, 5,  0, 32'h0000_0200, 5};
    vecs[11] = '{2'b10, 0, 0, 9, 0, 0, 9,  2'b10, 1, 0, 1, 9,  1, 32'h0000_0200, 5};
    vecs[12] = '{2'b00, 0, 0, 0, 0, 0, 9,  2'b00, 1, 0, 0, 9,  0, 32'h0, 5};
    vecs[13] = '{2'b00, 0, 0, 0, 0, 0, 9,  2'b00, 0, 0, 0, 9,  0, 32'h0, 5};
    vecs[14] = '{2'b01, 0, 12, 0, 0, 0, 12, 2'b01, 0, 0, 1, 12, 0, 32'h0, 5};
    vecs[15] = '{2'b00, 0, 0, 0, 1, 12, 12, 2'b00, 0, 0, 0, 12, 0, 32'h0000_1000, 5};
    vecs[16] = '{2'b00, 0, 0, 0, 0, 0, 12, 2'b00, 1, 1, 0, 12, 0, 32'h0000_1000, 5};
    vecs[17] = '{2'b00, 0, 0, 0, 1, 0, 0,  2'b00, 0, 1, 0, 12, 0, 32'h0000_1000, 5};
    vecs[18] = '{2'b01, 0, 0, 0, 0, 0, 0,  2'b01, 0, 1, 0, 0,  0, 32'h0000_1000, 5};

    async_reset   = 1'b0;
    req_valid     = 2'b00;
    req_addr_0    = '0;
    req_addr_1    = '0;
    req_data_0    = D0;
    req_data_1    = D1;
    hold          = 1'b0;
    reserve_valid = 1'b0;
    reserve_addr  = '0;
    check_addr_1  = '0;
    check_addr_2  = 5'd12;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", write_enable, 0);
    chk("rst_wa", write_addr, 0);
    chk("rst_wd", write_data, 0);
    chk("rst_pend", pending, 0);
    chk("rst_cnt", conflict_count, 0);
    @(negedge clock);
    async_reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      req_valid     = vecs[i].valid;
      hold          = vecs[i].hold;
      req_addr_0    = vecs[i].a0;
      req_addr_1    = vecs[i].a1;
      reserve_valid = vecs[i].rv;
      reserve_addr  = vecs[i].ra;
      check_addr_1  = vecs[i].chk;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vecs[i].exp_ready);
      chk($sformatf("v%0d_hz1", i), hazard_1, vecs[i].exp_hz1);
      chk($sformatf("v%0d_hz2", i), hazard_2, vecs[i].exp_hz2);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_we", i), write_enable, vecs[i].exp_we);
      chk($sformatf("v%0d_wa", i), write_addr, vecs[i].exp_wa);
      if (vecs[i].exp_we)
        chk($sformatf("v%0d_wd", i), write_data, vecs[i].exp_src ? D1 : D0);
      chk($sformatf("v%0d_pend", i), pending, vecs[i].exp_pend);
      chk($sformatf("v%0d_cnt", i), conflict_count, PERF ? vecs[i].exp_cnt : 16'd0);
    end

    // fill the scoreboard, then write register 1 on the last reservation cycle
    for (int r = 1; r < 32; r++) begin
      @(negedge clock);
      reserve_valid = 1'b1;
      reserve_addr  = 5'(r);
      req_valid     = (r == 31) ? 2'b01 : 2'b00;
      req_addr_0    = 5'd1;
    end
    @(posedge clock);
    #1;
    chk("mid_we", write_enable, 1);
    chk("mid_pend", pending, 32'hFFFF_FFFE);
    #2;
    async_reset = 1'b0;
    #1;
    chk("async_we", write_enable, 0);
    chk("async_pend", pending, 0);
    chk("async_wa", write_addr, 0);
    chk("async_cnt", conflict_count, 0);
    @(negedge clock);
    reserve_valid = 1'b0;
    req_valid     = 2'b11;
    req_addr_0    = 5'd3;
    req_addr_1    = 5'd7;
    async_reset   = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 2'b01);
    @(posedge clock);
    #1;
    chk("post_rst_wa", write_addr, 3);
    chk("post_rst_wd", write_data, D0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
